// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding control unit.
package pipeline_ctrl_pkg;

    // Records hold rd at this fixed width so the struct stays unparameterised.
    localparam int REC_AW = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic [REC_AW-1:0] rd;
    } stage_rec_t;

    function automatic int fwd_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_match.sv
// Youngest-match priority encoder of one ID source register over the in-flight
// writer records (stage 0 = EX is the youngest).
module hazard_match
    import pipeline_ctrl_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_AW = 5
) (
    input  stage_rec_t [STAGES-1:0]       recs,
    input  logic [REG_AW-1:0]             rs,
    input  logic                          used,
    output logic                          hit,
    output logic [$clog2(STAGES+1)-1:0]   index,
    output logic                          is_load
);

    localparam int IW = fwd_w(STAGES);

    logic [STAGES-1:0] match;
    logic [STAGES:0]   hit_c;
    logic [IW-1:0]     idx_c [STAGES+1];
    logic [STAGES:0]   load_c;

    assign hit_c[STAGES]  = 1'b0;
    assign idx_c[STAGES]  = '0;
    assign load_c[STAGES] = 1'b0;

    // Chain from the oldest stage toward stage 0 so the youngest match wins.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            assign match[gi]  = recs[gi].valid && recs[gi].reg_write && used &&
                                (rs != '0) && (recs[gi].rd == REC_AW'(rs));
            assign hit_c[gi]  = match[gi] || hit_c[gi+1];
            assign idx_c[gi]  = match[gi] ? IW'(gi) : idx_c[gi+1];
            assign load_c[gi] = match[gi] ? recs[gi].mem_read : load_c[gi+1];
        end
    endgenerate

    assign hit     = hit_c[0];
    assign index   = idx_c[0];
    assign is_load = load_c[0];

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard detection, stall/flush and operand-forwarding control for the core.
// Optional feature macro: PIPELINE_CTRL_FORWARDING_EN (enables forwarding selects).
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_AW = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [REG_AW-1:0]             id_rs1,
    input  logic [REG_AW-1:0]             id_rs2,
    input  logic                          id_rs1_used,
    input  logic                          id_rs2_used,
    input  logic [REG_AW-1:0]             id_rd,
    input  logic                          id_reg_write,
    input  logic                          id_mem_read,
    input  logic                          branch_taken,
    output logic                          stall,
    output logic                          flush,
    output logic [$clog2(STAGES+1)-1:0]   fwd_sel1,
    output logic [$clog2(STAGES+1)-1:0]   fwd_sel2,
    output logic                          wb_valid,
    output logic                          wb_reg_write,
    output logic [REG_AW-1:0]             wb_rd,
    output logic [$clog2(STAGES+1)-1:0]   inflight
);

    localparam int FW = fwd_w(STAGES);

    stage_rec_t [STAGES-1:0] stage_reg;
    stage_rec_t              stage0_next;
    logic [STAGES-1:0]       valid_vec;

    logic          hit1, hit2, load1, load2;
    logic [FW-1:0] idx1, idx2;
    logic          load_use, hazard;

    hazard_match #(.STAGES(STAGES), .REG_AW(REG_AW)) u_match_rs1 (
        .recs    (stage_reg),
        .rs      (id_rs1),
        .used    (id_rs1_used),
        .hit     (hit1),
        .index   (idx1),
        .is_load (load1)
    );

    hazard_match #(.STAGES(STAGES), .REG_AW(REG_AW)) u_match_rs2 (
        .recs    (stage_reg),
        .rs      (id_rs2),
        .used    (id_rs2_used),
        .hit     (hit2),
        .index   (idx2),
        .is_load (load2)
    );

    // A load still in EX cannot be forwarded: its data exists only after stage 1.
    assign load_use = (hit1 && (idx1 == '0) && load1) || (hit2 && (idx2 == '0) && load2);

`ifdef PIPELINE_CTRL_FORWARDING_EN
    assign hazard   = load_use;
    assign fwd_sel1 = (hit1 && !reset) ? idx1 + FW'(1) : FW'(FWD_RF);
    assign fwd_sel2 = (hit2 && !reset) ? idx2 + FW'(1) : FW'(FWD_RF);
`else
    // Load-use is a subset of "any match"; keeping it in the OR costs nothing.
    assign hazard   = hit1 || hit2 || load_use;
    assign fwd_sel1 = FW'(FWD_RF);
    assign fwd_sel2 = FW'(FWD_RF);
`endif

    assign stall = !reset && id_valid && hazard && !branch_taken;
    assign flush = branch_taken;

    always_comb begin
        stage0_next = '0;
        if (id_valid && !stall && !branch_taken) begin
            stage0_next.valid     = 1'b1;
            stage0_next.reg_write = id_reg_write;
            stage0_next.mem_read  = id_mem_read;
            stage0_next.rd        = REC_AW'(id_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], stage0_next};
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_valid
            assign valid_vec[gi] = stage_reg[gi].valid;
        end
    endgenerate

    assign wb_valid     = !reset && stage_reg[STAGES-1].valid;
    assign wb_reg_write = stage_reg[STAGES-1].reg_write;
    assign wb_rd        = stage_reg[STAGES-1].rd[REG_AW-1:0];
    assign inflight     = reset ? '0 : FW'($countones(valid_vec));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: STAGES=3 instance with a retirement
// scoreboard, plus a STAGES=5 instance for deep forwarding distances.
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_FORWARDING_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, id_valid, use5, branch_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;

    logic       stall3, flush3, wbv3, wbw3;
    logic [1:0] f1_3, f2_3, inf3;
    logic [4:0] wbrd3;
    logic       stall5, flush5, wbv5, wbw5;
    logic [2:0] f1_5, f2_5, inf5;
    logic [4:0] wbrd5;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] sb[$];
    logic [5:0] sb_exp;

    pipeline_ctrl #(.STAGES(3), .REG_AW(5)) dut3 (
        .clk(clk), .reset(reset), .id_valid(id_valid && !use5),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .branch_taken(branch_taken && !use5),
        .stall(stall3), .flush(flush3), .fwd_sel1(f1_3), .fwd_sel2(f2_3),
        .wb_valid(wbv3), .wb_reg_write(wbw3), .wb_rd(wbrd3), .inflight(inf3)
    );

    pipeline_ctrl #(.STAGES(5), .REG_AW(5)) dut5 (
        .clk(clk), .reset(reset), .id_valid(id_valid && use5),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .branch_taken(branch_taken && use5),
        .stall(stall5), .flush(flush5), .fwd_sel1(f1_5), .fwd_sel2(f2_5),
        .wb_valid(wbv5), .wb_reg_write(wbw5), .wb_rd(wbrd5), .inflight(inf5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int v, input int rs1, input int u1, input int rs2, input int u2,
                         input int rd, input int rw, input int mr, input int br);
        id_valid     = v[0];
        id_rs1       = 5'(rs1);
        id_rs1_used  = u1[0];
        id_rs2       = 5'(rs2);
        id_rs2_used  = u2[0];
        id_rd        = 5'(rd);
        id_reg_write = rw[0];
        id_mem_read  = mr[0];
        branch_taken = br[0];
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One cycle on the STAGES=3 instance; e_inf < 0 skips the occupancy check.
    task automatic step(input string tag, input int e_stall, input int e_f1, input int e_f2, input int e_inf);
        @(negedge clk);
        chk({tag, ".stall"}, 32'(stall3), 32'(e_stall));
        chk({tag, ".flush"}, 32'(flush3), 32'(branch_taken));
        chk({tag, ".fwd1"}, 32'(f1_3), 32'(e_f1));
        chk({tag, ".fwd2"}, 32'(f2_3), 32'(e_f2));
        if (e_inf >= 0) chk({tag, ".inflight"}, 32'(inf3), 32'(e_inf));
        if (reset) chk({tag, ".wb_valid"}, 32'(wbv3), 32'd0);
        if (id_valid && (e_stall == 0) && !branch_taken && !reset)
            sb.push_back({id_reg_write, id_rd});
        $display("step %s: stall=%0d fwd=%0d/%0d inflight=%0d", tag, stall3, f1_3, f2_3, inf3);
        @(posedge clk);
        #1;
    endtask

    // One cycle on the STAGES=5 instance; e_wbrd >= 0 also checks the WB writer.
    task automatic step5(input string tag, input int e_stall, input int e_f1, input int e_inf, input int e_wbrd);
        @(negedge clk);
        chk({tag, ".stall5"}, 32'(stall5), 32'(e_stall));
        chk({tag, ".flush5"}, 32'(flush5), 32'd0);
        chk({tag, ".fwd1_5"}, 32'(f1_5), 32'(e_f1));
        chk({tag, ".fwd2_5"}, 32'(f2_5), 32'd0);
        if (e_inf >= 0) chk({tag, ".inflight5"}, 32'(inf5), 32'(e_inf));
        if (e_wbrd >= 0) chk({tag, ".wb5"}, 32'({wbv5, wbw5, wbrd5}), 32'({2'b11, 5'(e_wbrd)}));
        $display("step5 %s: stall=%0d fwd1=%0d inflight=%0d", tag, stall5, f1_5, inf5);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) step("drain", 0, 0, 0, -1);
    endtask

    task automatic drain5(input int n);
        idle();
        for (int i = 0; i < n; i++) step5("drain5", 0, 0, -1, -1);
    endtask

    // Retirement scoreboard for the STAGES=3 instance.
    always @(negedge clk) begin
        if (wbv3) begin
            if (sb.size() == 0) begin
                chk("wb.extra", 32'(wbv3), 32'd0);
            end else begin
                sb_exp = sb.pop_front();
                chk("wb.retire", 32'({wbw3, wbrd3}), 32'(sb_exp));
                $display("retire rd=%0d we=%0d", wbrd3, wbw3);
            end
        end
    end

    initial begin
        reset = 1'b1;
        use5  = 1'b0;
        drive(1, 1, 1, 0, 0, 1, 1, 0, 0);
        step("rst_a", 0, 0, 0, 0);
        step("rst_b", 0, 0, 0, 0);
        reset = 1'b0;

        drive(1, 0, 0, 0, 0, 1, 1, 0, 0); step("fill1", 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0); step("fill2", 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0); step("fill3", 0, 0, 0, 2);
        idle();                           step("full", 0, 0, 0, 3);
        drain(3);

        // addi x5 ; add x6,x5,x5
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); step("addi", 0, 0, 0, 0);
        drive(1, 5, 1, 5, 1, 6, 1, 0, 0);
`ifdef PIPELINE_CTRL_FORWARDING_EN
        step("add_fwd", 0, 1, 1, 1);
`else
        step("add_s1", 1, 0, 0, 1);
        step("add_s2", 1, 0, 0, 1);
        step("add_s3", 1, 0, 0, 1);
        step("add_go", 0, 0, 0, 0);
`endif
        drain(3);

        // lw x7 ; add x8,x7,x0
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0); step("lw", 0, 0, 0, 0);
        drive(1, 7, 1, 0, 1, 8, 1, 0, 0); step("lu_stall", 1, 0, 0, 1);
`ifdef PIPELINE_CTRL_FORWARDING_EN
        step("lu_go", 0, 2, 0, 1);
`else
        step("lu_s2", 1, 0, 0, 1);
        step("lu_s3", 1, 0, 0, 1);
        step("lu_go", 0, 0, 0, 0);
`endif
        drain(3);

        // writer of x0, then reader of x0
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step("wr_x0", 0, 0, 0, 0);
        drive(1, 0, 1, 0, 1, 9, 1, 0, 0); step("rd_x0", 0, 0, 0, 1);
        drain(3);

        // taken branch while ID waits on a load: bubble instead of the consumer
        drive(1, 0, 0, 0, 0, 10, 1, 1, 0); step("lw2", 0, 0, 0, 0);
        drive(1, 10, 1, 0, 0, 11, 1, 0, 1); step("br_kill", 0, FWD_ON ? 1 : 0, 0, 1);
        idle();
        step("br_bub1", 0, 0, 0, 1);
        step("br_bub2", 0, 0, 0, 1);
        step("br_bub3", 0, 0, 0, 0);

        // reset mid-operation drops every in-flight writer
        drive(1, 0, 0, 0, 0, 11, 1, 0, 0); step("pre1", 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 12, 1, 0, 0); step("pre2", 0, 0, 0, 1);
        reset = 1'b1;
        sb.delete();
        drive(1, 12, 1, 0, 0, 13, 1, 0, 1); step("mid_rst", 0, 0, 0, 0);
        reset = 1'b0;
        drive(1, 12, 1, 11, 1, 14, 1, 0, 0); step("post_rst", 0, 0, 0, 0);
        drain(3);

        // STAGES=5: producer sitting in WB when the consumer is in ID
        use5 = 1'b1;
        drive(1, 0, 0, 0, 0, 20, 1, 0, 0); step5("p", 0, 0, 0, -1);
        drive(1, 0, 0, 0, 0, 21, 1, 0, 0); step5("f1", 0, 0, 1, -1);
        drive(1, 0, 0, 0, 0, 22, 1, 0, 0); step5("f2", 0, 0, 2, -1);
        drive(1, 0, 0, 0, 0, 23, 1, 0, 0); step5("f3", 0, 0, 3, -1);
        drive(1, 0, 0, 0, 0, 24, 1, 0, 0); step5("f4", 0, 0, 4, -1);
        drive(1, 20, 1, 0, 0, 25, 1, 0, 0);
        step5("far", FWD_ON ? 0 : 1, FWD_ON ? 5 : 0, 5, 20);
        drain5(5);

        // same rd written again by a younger instruction: the younger one wins
        drive(1, 0, 0, 0, 0, 20, 1, 0, 0); step5("p_old", 0, 0, 0, -1);
        drive(1, 0, 0, 0, 0, 21, 1, 0, 0); step5("g1", 0, 0, 1, -1);
        drive(1, 0, 0, 0, 0, 20, 1, 0, 0); step5("p_young", 0, 0, 2, -1);
        drive(1, 0, 0, 0, 0, 22, 1, 0, 0); step5("g2", 0, 0, 3, -1);
        drive(1, 0, 0, 0, 0, 23, 1, 0, 0); step5("g3", 0, 0, 4, -1);
        drive(1, 20, 1, 0, 0, 26, 1, 0, 0);
        step5("young", FWD_ON ? 0 : 1, FWD_ON ? 3 : 0, 5, 20);
        drain5(5);
        use5 = 1'b0;

        drain(1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
